mod_mul_arbiter: RTL and testbench
==================================

MOD_MUL_ARBITER -- requirements
Module: mod_mul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one modular multiplier (mod q = 8380417).
REQ-002 Parameter MUL_LAT, default 3: fixed multiplier latency in cycles, from issue to result; valid range 1..8.
REQ-003 Parameter BURST_LEN, default 4: maximum consecutive grants to one requester in burst mode.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  NUM_REQ  per-requester request strobe.
REQ-007 req_a, req_b  in  NUM_REQ*23 each  packed operands; requester i occupies bits [23i+22:23i].
REQ-008 req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-009 mul_valid, mul_a, mul_b  out  1, 23, 23  issue port to the external multiplier.
REQ-010 mul_res  in  23  multiplier result, valid exactly MUL_LAT cycles after the matching mul_valid.
REQ-011 rsp_valid  out  NUM_REQ  one-hot; marks the requester that owns rsp_data this cycle.
REQ-012 rsp_data  out  23  result routed to the owning requester.
REQ-013 range_err  out  1  sticky flag; set when an operand >= q is accepted.

Function
REQ-014 The block shall compute the grant combinationally from req_valid and the round-robin pointer; req_ready shall be one-hot or zero.
REQ-015 Round-robin: search starts at ptr; the lowest index >= ptr wins, with wrap-around to 0.
REQ-016 After each transfer from requester g, ptr shall become (g+1) mod NUM_REQ.
REQ-017 With no req_valid asserted, req_ready shall be 0 and ptr shall hold.
REQ-018 mul_valid, mul_a and mul_b shall be registered: one cycle after a transfer they carry the granted operands. At most one issue per cycle; throughput is 1 per cycle.
REQ-019 A tag pipeline of depth MUL_LAT+1 shall carry {valid, owner index} alongside each issue.
REQ-020 rsp_valid[i] shall assert exactly MUL_LAT+1 cycles after the transfer cycle of requester i, with rsp_data = mul_res.
REQ-021 Responses shall have no backpressure; requesters shall accept rsp_valid unconditionally.
REQ-022 Response order shall equal issue order.
REQ-023 An operand >= 8380417 shall still be forwarded, and range_err shall set and stay set until reset.
REQ-024 If requester i deasserts req_valid without being granted, the block shall not record its request.

Reset
REQ-025 While rst_n is low, the following shall be 0: req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_data, range_err, ptr, the burst counter and every tag-pipeline entry. The state shall be IDLE.
REQ-026 A reset asserted mid-operation shall discard all in-flight tags, and no rsp_valid shall follow the release of reset.
REQ-027 The first grant shall occur no earlier than the first rising edge after rst_n is released.

Configuration
REQ-028 Macro MOD_MUL_ARBITER_BURST_EN enables burst lock. When the macro is not defined, pure round-robin per REQ-015..REQ-016 applies.
REQ-029 With the macro defined, the FSM states shall be IDLE and LOCK:
- IDLE->LOCK on a transfer: record the owner and set cnt=1.
- In LOCK, the owner keeps priority while req_valid[owner]=1 and cnt<BURST_LEN; each transfer increments cnt.
- LOCK->IDLE when req_valid[owner]=0 or cnt reaches BURST_LEN. On this exit, ptr=(owner+1) mod NUM_REQ.
- While the owner is idle in LOCK, no other requester shall be granted in that cycle.

Verification
REQ-030 All four requesters hold req_valid continuously -> grants cycle 0,1,2,3,0; each rsp_valid arrives exactly MUL_LAT+1=4 cycles after its transfer.
REQ-031 Requester 2 issues a=8380416, b=2 with a model multiplier -> rsp_data=8380415 on rsp_valid[2]; range_err stays 0.
REQ-032 Requester 1 issues a=8380417 -> the operation is issued and range_err=1 persists through later traffic.
REQ-033 rst_n is pulsed low while 3 operations are in flight -> all outputs are 0 immediately, and no rsp_valid appears in the following 10 cycles.
REQ-034 With MOD_MUL_ARBITER_BURST_EN defined, requesters 0 and 3 are continuously valid -> grants are 0,0,0,0,3,3,3,3,0. Without the macro, the same stimulus gives 0,3,0,3.
REQ-035 Only requester 3 is valid, then requester 0 is added in the same cycle that 3 completes -> ptr wraps and requester 0 is granted next.

Source files
------------

// File: rtl/mod_mul_arbiter.sv
// Round-robin arbiter sharing one fixed-latency mod-q multiplier among NUM_REQ requesters.
// Define MOD_MUL_ARBITER_BURST_EN to let a granted requester keep the multiplier for up to BURST_LEN transfers.
`timescale 1ns/1ps
module mod_mul_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MUL_LAT   = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*23-1:0] req_a,
  input  logic [NUM_REQ*23-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  mul_valid,
  output logic [22:0]           mul_a,
  output logic [22:0]           mul_b,
  input  logic [22:0]           mul_res,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [22:0]           rsp_data,
  output logic                  range_err
);

  localparam int DW        = 23;
  localparam logic [DW-1:0] MOD_Q = 23'd8380417;
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TAG_DEPTH = MUL_LAT + 1;
`ifdef MOD_MUL_ARBITER_BURST_EN
  localparam int BURST_MAX = BURST_LEN;
`else
  localparam int BURST_MAX = 1;
`endif
  localparam int CNT_W     = $clog2(BURST_MAX + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic valid;
    idx_t owner;
  } tag_t;
  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state_q, state_d;
  idx_t          ptr_q, ptr_d;
  idx_t          owner_q, owner_d;
  cnt_t          cnt_q, cnt_d;
  logic          mul_valid_q, mul_valid_d;
  logic [DW-1:0] mul_a_q, mul_a_d;
  logic [DW-1:0] mul_b_q, mul_b_d;
  logic          range_err_q, range_err_d;
  tag_t          tag_q [TAG_DEPTH];
  tag_t          tag_d [TAG_DEPTH];

  logic          rr_found;
  idx_t          rr_idx;
  idx_t          cand;
  logic          gnt_found;
  idx_t          gnt_idx;
  logic          xfer;
  logic [DW-1:0] sel_a, sel_b;

  function automatic idx_t next_idx(input idx_t i);
    return (i == idx_t'(NUM_REQ - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // Round-robin search: lowest valid index at or above ptr, wrapping to 0.
  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = idx_t'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  // While locked, only the owner may be granted; an idle owner blocks everyone for that cycle.
  always_comb begin
    gnt_found = rr_found;
    gnt_idx   = rr_idx;
    if (state_q == LOCK) begin
      gnt_found = req_valid[owner_q];
      gnt_idx   = owner_q;
    end
    xfer  = gnt_found && rst_n;
    sel_a = req_a[gnt_idx*DW +: DW];
    sel_b = req_b[gnt_idx*DW +: DW];
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (gnt_idx == idx_t'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mul_valid_d = xfer;
    mul_a_d     = xfer ? sel_a : mul_a_q;
    mul_b_d     = xfer ? sel_b : mul_b_q;
    range_err_d = range_err_q | (xfer && ((sel_a >= MOD_Q) || (sel_b >= MOD_Q)));

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (BURST_MAX <= 1) begin
            ptr_d = next_idx(gnt_idx);
          end else begin
            state_d = LOCK;
            owner_d = gnt_idx;
            cnt_d   = cnt_t'(1);
          end
        end
      end
      LOCK: begin
        if (!xfer || (cnt_q == cnt_t'(BURST_MAX - 1))) begin
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    tag_d[0] = '{valid: xfer, owner: gnt_idx};
    for (int k = 1; k < TAG_DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      range_err_q <= 1'b0;
      // NOTE: the tag pipeline is reset entry by entry so a reset drops every in-flight response.
      for (int k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      range_err_q <= range_err_d;
      for (int k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  // The oldest tag lines up with mul_res, so the result is routed straight through.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tag_q[MUL_LAT].valid && (tag_q[MUL_LAT].owner == idx_t'(i));
    end
    rsp_data = (|rsp_valid) ? mul_res : '0;
  end

  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Self-checking bench for mod_mul_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_mod_mul_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MUL_LAT   = 3;
  localparam int BURST_LEN = 4;
  localparam longint unsigned Q = 64'd8380417;
  localparam int MAXC = 2048;
`ifdef MOD_MUL_ARBITER_BURST_EN
  localparam int BMAX = BURST_LEN;
`else
  localparam int BMAX = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*23-1:0] req_a = '0;
  logic [NUM_REQ*23-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_valid;
  logic [22:0]           mul_a, mul_b, mul_res;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [22:0]           rsp_data;
  logic                  range_err;

  always #5 clk = ~clk;

  mod_mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_res(mul_res),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .range_err(range_err)
  );

  // External multiplier model: product mod q appears MUL_LAT cycles after mul_valid, junk otherwise.
  logic [22:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= mul_valid ? 23'((64'(mul_a) * 64'(mul_b)) % Q) : 23'($urandom);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_res = mpipe[MUL_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int          m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit          m_lock = 0, m_rerr = 0;
  bit          pend_v = 0;
  logic [22:0] pend_a = '0, pend_b = '0;
  bit          exp_v   [MAXC];
  int          exp_own [MAXC];
  logic [22:0] exp_dat [MAXC];
  int          grants [$];
  logic [22:0] last_rsp_data = '0;
  logic [NUM_REQ-1:0] last_rsp_valid = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  function automatic int model_grant();
    if (m_lock) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (req_valid[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic model_advance(input int g);
    if (m_lock) begin
      if (g < 0) begin
        m_lock = 0;
        m_ptr  = (m_owner + 1) % NUM_REQ;
      end else begin
        m_cnt++;
        if (m_cnt >= BMAX) begin
          m_lock = 0;
          m_ptr  = (m_owner + 1) % NUM_REQ;
        end
      end
    end else if (g >= 0) begin
      if (BMAX > 1) begin
        m_lock = 1; m_owner = g; m_cnt = 1;
      end else begin
        m_ptr = (g + 1) % NUM_REQ;
      end
    end
  endtask

  // One clock cycle: called just after a negedge with inputs already driven.
  task automatic step();
    int g;
    logic [22:0] a, b;
    logic [NUM_REQ-1:0] exp_rdy, exp_rsp;
    #1;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_mul_valid", mul_valid, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_range_err", range_err, 0);
      m_ptr = 0; m_lock = 0; m_cnt = 0; m_rerr = 0; pend_v = 0;
      for (int i = cyc; i < MAXC; i++) exp_v[i] = 0;
    end else begin
      g = model_grant();
      exp_rdy = (g >= 0) ? NUM_REQ'(1) << g : '0;
      check("req_ready", req_ready, exp_rdy);
      check("mul_valid", mul_valid, pend_v);
      if (pend_v) begin
        check("mul_a", mul_a, pend_a);
        check("mul_b", mul_b, pend_b);
      end
      exp_rsp = exp_v[cyc] ? NUM_REQ'(1) << exp_own[cyc] : '0;
      check("rsp_valid", rsp_valid, exp_rsp);
      if (exp_v[cyc]) check("rsp_data", rsp_data, exp_dat[cyc]);
      check("range_err", range_err, m_rerr);
      if (|rsp_valid) begin
        last_rsp_valid = rsp_valid;
        last_rsp_data  = rsp_data;
      end
      grants.push_back(g);
      if (g >= 0) begin
        a = req_a[g*23 +: 23];
        b = req_b[g*23 +: 23];
        pend_v = 1; pend_a = a; pend_b = b;
        exp_v[cyc + MUL_LAT + 1]   = 1;
        exp_own[cyc + MUL_LAT + 1] = g;
        exp_dat[cyc + MUL_LAT + 1] = 23'((64'(a) * 64'(b)) % Q);
        if (64'(a) >= Q || 64'(b) >= Q) m_rerr = 1;
      end else begin
        pend_v = 0;
      end
      model_advance(g);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [22:0] a, input logic [22:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*23 +: 23] = a;
    req_b[i*23 +: 23] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*23 +: 23] = 23'($urandom_range(0, 8380416));
      req_b[i*23 +: 23] = 23'($urandom_range(0, 8380416));
    end
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_pulse();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int e030 [5];
    int e034 [9];
    int e035 [3];
`ifdef MOD_MUL_ARBITER_BURST_EN
    e030 = '{0, 0, 0, 0, 1};
    e034 = '{0, 0, 0, 0, 3, 3, 3, 3, 0};
    e035 = '{3, -1, 0};
`else
    e030 = '{0, 1, 2, 3, 0};
    e034 = '{0, 3, 0, 3, 0, 3, 0, 3, 0};
    e035 = '{3, 0, 0};
`endif
    for (int i = 0; i < MAXC; i++) exp_v[i] = 0;

    // Reset with everyone requesting: nothing may be granted.
    @(negedge clk);
    req_valid = '1;
    rand_ops();
    step();
    step();
    rst_n = 1'b1;

    // All four requesters continuously valid.
    s = grants.size();
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      step();
    end
    for (int i = 0; i < 5; i++) check("rr_all_seq", 64'(grants[s+i]), 64'(e030[i]));
    idle(8);

    // Largest in-range operand times 2 on requester 2.
    req_valid = '0;
    set_req(2, 23'd8380416, 23'd2);
    step();
    idle(MUL_LAT + 2);
    check("max_op_rsp_valid", last_rsp_valid, 4'b0100);
    check("max_op_rsp_data", last_rsp_data, 23'd8380415);
    check("max_op_range_err", range_err, 0);

    // Out-of-range operand on requester 1: forwarded, flag sticks.
    set_req(1, 23'd8380417, 23'd3);
    step();
    idle(2);
    check("range_err_set", range_err, 1);

    // Random traffic with random valid masks.
    for (int i = 0; i < 300; i++) begin
      req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      rand_ops();
      if ($urandom_range(0, 15) == 0) req_a[0 +: 23] = 23'($urandom_range(8380417, 8388607));
      step();
    end
    idle(MUL_LAT + 2);
    check("range_err_sticky", range_err, 1);

    // Reset with three operations in flight.
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      req_valid = '0;
      set_req(i, 23'($urandom_range(0, 8380416)), 23'($urandom_range(0, 8380416)));
      step();
    end
    reset_pulse();
    s = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = '0;
      step();
      if (|rsp_valid) s++;
    end
    check("no_rsp_after_reset", 64'(s), 0);

    // Requester 3 alone, then requester 0 takes over as 3 drops.
    s = grants.size();
    req_valid = '0;
    set_req(3, 23'd11, 23'd13);
    step();
    req_valid = '0;
    set_req(0, 23'd17, 23'd19);
    step();
    step();
    for (int i = 0; i < 3; i++) check("wrap_seq", 64'(grants[s+i]), 64'(e035[i]));
    idle(MUL_LAT + 2);

    // Requesters 0 and 3 continuously valid from a fresh pointer.
    reset_pulse();
    s = grants.size();
    req_valid = '0;
    for (int i = 0; i < 9; i++) begin
      set_req(0, 23'($urandom_range(0, 8380416)), 23'($urandom_range(0, 8380416)));
      set_req(3, 23'($urandom_range(0, 8380416)), 23'($urandom_range(0, 8380416)));
      step();
    end
    for (int i = 0; i < 9; i++) check("pair_seq", 64'(grants[s+i]), 64'(e034[i]));
    idle(MUL_LAT + 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
